// File: rtl/bp_pkg.sv
// Shared types and helpers for the speculative global-history branch predictor:
// FSM state encoding, saturating counter arithmetic and the PHT index hash.
package bp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [31:0] cnt_max(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int cnt_w);
        return (cnt >= cnt_max(cnt_w)) ? cnt : cnt + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] cnt);
        return (cnt == 32'd0) ? cnt : cnt - 32'd1;
    endfunction

    // Mode 0 concatenates low PC bits above the history; mode 1 xor-folds
    // pc[31:2]^hr into index_w bits so long histories still use every PC bit.
    function automatic logic [31:0] bp_hash(input logic [31:0] pc,
                                            input logic [31:0] hr,
                                            input int          index_w,
                                            input int          hr_w,
                                            input int          mode);
        logic [31:0] hr_mask;
        logic [31:0] idx_mask;
        logic [31:0] v;
        logic [31:0] res;
        hr_mask  = (32'd1 << hr_w) - 32'd1;
        idx_mask = (32'd1 << index_w) - 32'd1;
        res      = '0;
        if (mode == 0) begin
            res = (((pc >> 2) << hr_w) | (hr & hr_mask)) & idx_mask;
        end else begin
            v = (pc >> 2) ^ (hr & hr_mask);
            for (int i = 0; i < 32; i++) begin
                if (((v >> i) & 32'd1) != 32'd0) begin
                    res = res ^ (32'd1 << (i % index_w));
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/speculative_history_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor: prediction handshake,
// in-order resolve, flush and status.
interface speculative_history_predictor_if #(
    parameter int CNT_W    = 2,
    parameter int INFLIGHT = 4
);
    localparam int OCC_W = $clog2(INFLIGHT + 1);

    logic             pred_req;
    logic [31:0]      pred_pc;
    logic             pred_ready;
    logic             pred_taken;
    logic [CNT_W-1:0] pred_count;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             mispredict;
    logic             flush;
    logic             busy;
    logic [OCC_W-1:0] inflight_cnt;

    modport master (
        output pred_req, pred_pc, resolve_valid, resolve_taken, flush,
        input  pred_ready, pred_taken, pred_count, mispredict, busy, inflight_cnt
    );

    modport slave (
        input  pred_req, pred_pc, resolve_valid, resolve_taken, flush,
        output pred_ready, pred_taken, pred_count, mispredict, busy, inflight_cnt
    );

endinterface

// File: rtl/bp_inflight_fifo.sv
// Circular FIFO of unresolved branch checkpoints; head is visible combinationally
// so the resolve path can compare and restore in the same cycle.
module bp_inflight_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [DATA_W-1:0]          head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                       (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign head_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/speculative_history_predictor.sv
// Global-history direction predictor: hashed PHT of saturating counters, speculative
// history with per-branch checkpoints, in-order resolve and mispredict/flush recovery.
module speculative_history_predictor
    import bp_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int CNT_INIT  = 1,
    parameter int INDEX_W   = 12,
    parameter int HR_W      = 8,
    parameter int INFLIGHT  = 4,
    parameter int HASH_MODE = 0
) (
    input logic                           clk,
    input logic                           rst_n,
    speculative_history_predictor_if.slave bus
);
    localparam int                DEPTH      = 1 << INDEX_W;
    localparam int                OCC_W      = $clog2(INFLIGHT + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT_V = CNT_W'(CNT_INIT);

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [CNT_W-1:0]   count;
        logic               dir;
        logic [HR_W-1:0]    snapshot;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, init_idx_d;
    logic [HR_W-1:0]    ghr_q, ghr_d;
    logic [CNT_W-1:0]   pht_q [DEPTH];

    logic               busy;
    logic               run;
    logic               pht_we;
    logic [INDEX_W-1:0] pht_waddr;
    logic [CNT_W-1:0]   pht_wdata;

    logic [INDEX_W-1:0] pred_idx;
    logic [CNT_W-1:0]   pred_count;
    logic               pred_taken;
    logic               pred_ready;
    logic               accept;
    logic               resolve_fire;
    logic               mispredict;

    entry_t             head;
    entry_t             push_entry;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    logic [OCC_W-1:0]   fifo_count;

    // ---------------- INIT/RUN FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + INDEX_W'(1);
                if (&init_idx_q) state_d = ST_RUN;
            end
            default: state_d = state_q;
        endcase
    end

    // The PHT write port is shared: INIT sweeps the clear value, RUN trains on resolve.
    always_comb begin
        busy      = 1'b0;
        run       = 1'b0;
        pht_we    = 1'b0;
        pht_waddr = init_idx_q;
        pht_wdata = CNT_INIT_V;
        case (state_q)
            ST_INIT: begin
                busy   = 1'b1;
                pht_we = 1'b1;
            end
            default: begin
                run       = 1'b1;
                pht_we    = resolve_fire;
                pht_waddr = head.index;
                pht_wdata = bus.resolve_taken ? CNT_W'(sat_inc(32'(head.count), CNT_W))
                                              : CNT_W'(sat_dec(32'(head.count)));
            end
        endcase
    end

    // ---------------- Prediction ----------------
    assign pred_idx = INDEX_W'(bp_hash(bus.pred_pc, 32'(ghr_q), INDEX_W, HR_W, HASH_MODE));

    // A counter being written this cycle is forwarded so a same-index read never sees stale data.
    always_comb begin
        pred_count = pht_q[pred_idx];
        if (pht_we && (pht_waddr == pred_idx)) pred_count = pht_wdata;
    end

    assign pred_taken   = pred_count[CNT_W-1];
    assign resolve_fire = run && bus.resolve_valid && !fifo_empty;
    assign mispredict   = resolve_fire && (bus.resolve_taken != head.dir);
    assign pred_ready   = run && !fifo_full && !bus.flush && !mispredict;
    assign accept       = bus.pred_req && pred_ready;

    always_ff @(posedge clk) begin
        if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    end

    // ---------------- Speculative history ----------------
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {head.snapshot[HR_W-2:0], bus.resolve_taken};
        end else if (bus.flush) begin
            if (!fifo_empty) ghr_d = head.snapshot;
        end else if (accept) begin
            ghr_d = {ghr_q[HR_W-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

    // ---------------- In-flight checkpoints ----------------
    assign push_entry = '{index: pred_idx, count: pred_count, dir: pred_taken, snapshot: ghr_q};
    assign head       = entry_t'(fifo_head);

    bp_inflight_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (INFLIGHT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_entry),
        .pop       (resolve_fire),
        .clear     (mispredict || bus.flush),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign bus.pred_ready   = pred_ready;
    assign bus.pred_taken   = pred_taken;
    assign bus.pred_count   = pred_count;
    assign bus.mispredict   = mispredict;
    assign bus.busy         = busy;
    assign bus.inflight_cnt = fifo_count;

endmodule

// File: tb/tb_speculative_history_predictor.sv
// Directed bench for speculative_history_predictor (default parameters: 2-bit counters,
// 4096-entry PHT indexed {pc[5:2], ghr[7:0]}, 4 in flight).
module tb_speculative_history_predictor;

    localparam int CNT_W    = 2;
    localparam int INFLIGHT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    speculative_history_predictor_if #(.CNT_W(CNT_W), .INFLIGHT(INFLIGHT)) bus ();

    speculative_history_predictor #(
        .CNT_W     (CNT_W),
        .CNT_INIT  (1),
        .INDEX_W   (12),
        .HR_W      (8),
        .INFLIGHT  (INFLIGHT),
        .HASH_MODE (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pred_req      = 1'b0;
        bus.pred_pc       = '0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
    endtask

    // Counts cycles with busy high, bounded so a stuck INIT still reaches the summary.
    task automatic wait_init(output int n);
        n = 0;
        #2;
        while (bus.busy === 1'b1 && n < 5000) begin
            n++;
            tick();
            #2;
        end
    endtask

    // One branch predicted then resolved next cycle; FIFO must be empty on entry.
    task automatic branch(input logic [31:0] pc, input logic taken);
        bus.pred_req = 1'b1;
        bus.pred_pc  = pc;
        tick();
        bus.pred_req      = 1'b0;
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = taken;
        tick();
        bus.resolve_valid = 1'b0;
    endtask

    // Eight correctly-predicted not-taken branches shift the history back to zero.
    task automatic drain_history();
        repeat (8) branch(32'h0000_0104, 1'b0);
    endtask

    task automatic check_pht_all_init(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (dut.pht_q[i] !== 2'd1) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL %s: %0d entries differ, want 0 differing from 1", name, bad); end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        #2;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        tests++; if (bus.pred_ready !== 1'b0) begin fails++; $display("FAIL reset_pred_ready: got %b want 0", bus.pred_ready); end
        tests++; if (bus.mispredict !== 1'b0) begin fails++; $display("FAIL reset_mispredict: got %b want 0", bus.mispredict); end
        tests++; if (bus.inflight_cnt !== 3'd0) begin fails++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight_cnt); end
        tests++; if (dut.ghr_q !== 8'h00) begin fails++; $display("FAIL reset_ghr: got %h want 00", dut.ghr_q); end
        rst_n = 1'b1;
        wait_init(n);
        tests++; if (n != 4096) begin fails++; $display("FAIL init_busy_cycles: got %0d want 4096", n); end
        check_pht_all_init("init_pht_clear");
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_0100;
        #2;
        tests++; if (bus.pred_ready !== 1'b1) begin fails++; $display("FAIL run_pred_ready: got %b want 1", bus.pred_ready); end
        tests++; if (bus.pred_taken !== 1'b0 || bus.pred_count !== 2'd1) begin
            fails++; $display("FAIL init_predict: got taken=%b count=%0d want taken=0 count=1", bus.pred_taken, bus.pred_count); end
        bus.pred_req = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic       exp_tk  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            bus.pred_req = 1'b1;
            bus.pred_pc  = 32'h0000_0100;
            #2;
            tests++; if (bus.pred_count !== exp_cnt[k] || bus.pred_taken !== exp_tk[k]) begin
                fails++; $display("FAIL sat_predict_%0d: got count=%0d taken=%b want count=%0d taken=%b",
                                  k, bus.pred_count, bus.pred_taken, exp_cnt[k], exp_tk[k]); end
            tick();
            bus.pred_req      = 1'b0;
            bus.resolve_valid = 1'b1;
            bus.resolve_taken = 1'b1;
            #2;
            tests++; if (bus.mispredict !== ~exp_tk[k]) begin
                fails++; $display("FAIL sat_mispredict_%0d: got %b want %b", k, bus.mispredict, ~exp_tk[k]); end
            tick();
            bus.resolve_valid = 1'b0;
            drain_history();
        end
        #2;
        tests++; if (dut.pht_q[12'h000] !== 2'd3) begin fails++; $display("FAIL sat_pht_max: got %0d want 3", dut.pht_q[12'h000]); end
        tests++; if (dut.ghr_q !== 8'h00) begin fails++; $display("FAIL sat_ghr_drained: got %h want 00", dut.ghr_q); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_0108;
        tick();
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        #2;
        tests++; if (bus.pred_count !== 2'd0) begin fails++; $display("FAIL b2b_bypass_count: got %0d want 0", bus.pred_count); end
        tests++; if (bus.pred_ready !== 1'b1 || bus.mispredict !== 1'b0) begin
            fails++; $display("FAIL b2b_ready: got ready=%b mispredict=%b want ready=1 mispredict=0", bus.pred_ready, bus.mispredict); end
        tick();
        bus.pred_req = 1'b0;
        #2;
        tests++; if (bus.inflight_cnt !== 3'd1) begin fails++; $display("FAIL b2b_occupancy: got %0d want 1", bus.inflight_cnt); end
        tick();
        bus.resolve_valid = 1'b0;
        #2;
        tests++; if (bus.inflight_cnt !== 3'd0 || dut.pht_q[12'h200] !== 2'd0) begin
            fails++; $display("FAIL b2b_sat_zero: got cnt=%0d pht=%0d want cnt=0 pht=0", bus.inflight_cnt, dut.pht_q[12'h200]); end
        tick();
    endtask

    task automatic test_full();
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_010C;
        repeat (4) tick();
        #2;
        tests++; if (bus.inflight_cnt !== 3'd4) begin fails++; $display("FAIL full_occupancy: got %0d want 4", bus.inflight_cnt); end
        tests++; if (bus.pred_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", bus.pred_ready); end
        tick();
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        #2;
        tests++; if (bus.pred_ready !== 1'b0 || bus.mispredict !== 1'b0) begin
            fails++; $display("FAIL full_no_passthrough: got ready=%b mispredict=%b want 0 0", bus.pred_ready, bus.mispredict); end
        tick();
        bus.pred_req = 1'b0;
        #2;
        tests++; if (bus.inflight_cnt !== 3'd3) begin fails++; $display("FAIL full_pop: got %0d want 3", bus.inflight_cnt); end
        repeat (3) tick();
        bus.resolve_valid = 1'b0;
        #2;
        tests++; if (bus.inflight_cnt !== 3'd0 || dut.pht_q[12'h300] !== 2'd0) begin
            fails++; $display("FAIL full_drain: got cnt=%0d pht=%0d want 0 0", bus.inflight_cnt, dut.pht_q[12'h300]); end
        tick();
    endtask

    task automatic test_mispredict();
        branch(32'h0000_0110, 1'b1);
        branch(32'h0000_0110, 1'b0);
        branch(32'h0000_0110, 1'b1);
        #2;
        tests++; if (dut.ghr_q !== 8'h05) begin fails++; $display("FAIL mp_setup_ghr: got %h want 05", dut.ghr_q); end
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_0114;
        repeat (3) tick();
        #2;
        tests++; if (bus.inflight_cnt !== 3'd3 || dut.ghr_q !== 8'h28) begin
            fails++; $display("FAIL mp_push3: got cnt=%0d ghr=%h want cnt=3 ghr=28", bus.inflight_cnt, dut.ghr_q); end
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        #2;
        tests++; if (bus.mispredict !== 1'b1 || bus.pred_ready !== 1'b0) begin
            fails++; $display("FAIL mp_flag: got mispredict=%b ready=%b want 1 0", bus.mispredict, bus.pred_ready); end
        tick();
        bus.pred_req      = 1'b0;
        bus.resolve_valid = 1'b0;
        #2;
        tests++; if (dut.ghr_q !== 8'h0B) begin fails++; $display("FAIL mp_ghr_restore: got %h want 0b", dut.ghr_q); end
        tests++; if (bus.inflight_cnt !== 3'd0) begin fails++; $display("FAIL mp_fifo_clear: got %0d want 0", bus.inflight_cnt); end
        tests++; if (dut.pht_q[12'h505] !== 2'd2) begin fails++; $display("FAIL mp_pht_train: got %0d want 2", dut.pht_q[12'h505]); end
        tick();
    endtask

    task automatic test_flush();
        drain_history();
        branch(32'h0000_0118, 1'b1);
        branch(32'h0000_0118, 1'b0);
        branch(32'h0000_0118, 1'b0);
        branch(32'h0000_0118, 1'b1);
        branch(32'h0000_0118, 1'b0);
        #2;
        tests++; if (dut.ghr_q !== 8'h12) begin fails++; $display("FAIL flush_setup_ghr: got %h want 12", dut.ghr_q); end
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_011C;
        repeat (2) tick();
        bus.flush = 1'b1;
        #2;
        tests++; if (bus.pred_ready !== 1'b0 || bus.mispredict !== 1'b0) begin
            fails++; $display("FAIL flush_ready: got ready=%b mispredict=%b want 0 0", bus.pred_ready, bus.mispredict); end
        tick();
        bus.flush    = 1'b0;
        bus.pred_req = 1'b0;
        #2;
        tests++; if (dut.ghr_q !== 8'h12) begin fails++; $display("FAIL flush_ghr: got %h want 12", dut.ghr_q); end
        tests++; if (bus.inflight_cnt !== 3'd0) begin fails++; $display("FAIL flush_fifo: got %0d want 0", bus.inflight_cnt); end
        tests++; if (dut.pht_q[12'h712] !== 2'd1 || dut.pht_q[12'h724] !== 2'd1) begin
            fails++; $display("FAIL flush_no_pht_write: got %0d %0d want 1 1", dut.pht_q[12'h712], dut.pht_q[12'h724]); end
        tick();
    endtask

    task automatic test_reset_mid_init();
        int n;
        bus.pred_req = 1'b1;
        bus.pred_pc  = 32'h0000_0100;
        repeat (2) tick();
        bus.pred_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        tests++; if (bus.inflight_cnt !== 3'd0 || bus.busy !== 1'b1 || dut.ghr_q !== 8'h00) begin
            fails++; $display("FAIL rst_run_state: got cnt=%0d busy=%b ghr=%h want 0 1 00", bus.inflight_cnt, bus.busy, dut.ghr_q); end
        repeat (100) tick();
        #2;
        tests++; if (dut.init_idx_q !== 12'd100) begin fails++; $display("FAIL rst_mid_index: got %0d want 100", dut.init_idx_q); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init(n);
        tests++; if (n != 4096) begin fails++; $display("FAIL rst_mid_restart_cycles: got %0d want 4096", n); end
        check_pht_all_init("rst_mid_pht_clear");
        tests++; if (bus.inflight_cnt !== 3'd0 || bus.pred_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid_run: got cnt=%0d ready=%b want 0 1", bus.inflight_cnt, bus.pred_ready); end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_saturation();
        test_back_to_back();
        test_full();
        test_mispredict();
        test_flush();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached want bench completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
